tinker_mem_arb: RTL and testbench



---
 rtl/tinker_mem_arb_if.sv | 28 ++
 rtl/tinker_mem_arb.sv | 156 +++++++++++++++
 tb/tb_tinker_mem_arb.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/tinker_mem_arb_if.sv
// Request/response bundle for tinker_mem_arb: NUM_CH requesters sharing one
// sized, big-endian memory port with a shared response data bus.
interface tinker_mem_arb_if #(
    parameter int NUM_CH = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
) ();
    logic [NUM_CH-1:0]        req_valid;
    logic [NUM_CH-1:0]        req_ready;
    logic [NUM_CH-1:0]        req_we;
    logic [2*NUM_CH-1:0]      req_size;
    logic [ADDR_W*NUM_CH-1:0] req_addr;
    logic [DATA_W*NUM_CH-1:0] req_wdata;
    logic [NUM_CH-1:0]        resp_valid;
    logic [DATA_W-1:0]        resp_rdata;
    logic                     resp_err;
    logic                     busy;

    modport master (
        output req_valid, req_we, req_size, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err, busy
    );

    modport slave (
        input  req_valid, req_we, req_size, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err, busy
    );
endinterface

// File: rtl/tinker_mem_arb.sv
// Round-robin arbitrated, fixed-latency byte memory; one transaction in flight,
// sized big-endian accesses committed on the same edge the response rises.
module tinker_mem_arb #(
    parameter int NUM_CH    = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 64,
    parameter int MEM_BYTES = 524288,
    parameter int LATENCY   = 2
) (
    input  logic            clk,
    input  logic            reset,
    tinker_mem_arb_if.slave bus
);
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int MEM_AW    = $clog2(MEM_BYTES);
    localparam int MAX_BYTES = DATA_W / 8;
    localparam int CNT_W     = (LATENCY > 2) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0]  CNT_TERM  = CNT_W'((LATENCY > 1) ? LATENCY - 2 : 0);
    localparam logic [ADDR_W:0]   MEM_LIMIT = (ADDR_W + 1)'(MEM_BYTES);
    localparam logic [1:0]        SIZE_MAX  = (DATA_W == 64) ? 2'd3 : 2'd2;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;
    localparam logic [1:0] ST_AFTER_ACCEPT = (LATENCY == 1) ? ST_RESP : ST_WAIT;

    logic [1:0]        state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg;
    logic [CH_W-1:0]   rr_ptr_reg, grant_idx, next_ptr, ch_reg;
    logic [CH_W-1:0]   cand_idx [NUM_CH];
    logic              grant_found, grant_en, accept;
    logic [NUM_CH-1:0] req_ready_c;

    logic              we_reg;
    logic [1:0]        size_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] wdata_reg;

    logic [NUM_CH-1:0] resp_valid_reg;
    logic [DATA_W-1:0] resp_rdata_reg, rdata_next;
    logic              resp_err_reg;

    logic [3:0]        n_bytes;
    logic [ADDR_W:0]   end_addr;
    logic              fault;
    logic [MEM_AW-1:0] lane_addr [MAX_BYTES];

    logic [7:0] mem [MEM_BYTES];

    // Candidate order for the round-robin search, starting at rr_ptr.
    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_cand
            assign cand_idx[gi] = CH_W'((32'(rr_ptr_reg) + 32'(gi)) % NUM_CH);
        end
    endgenerate

    // Walk from the farthest candidate back so the nearest valid one wins.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int off = NUM_CH - 1; off >= 0; off--) begin
            if (bus.req_valid[cand_idx[off]]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx[off];
            end
        end
    end

    assign grant_en = (state_reg == ST_IDLE) || (state_reg == ST_RESP);

    always_comb begin
        req_ready_c = '0;
        if (grant_en && grant_found) req_ready_c[grant_idx] = 1'b1;
    end

    assign accept   = |(bus.req_valid & req_ready_c);
    assign next_ptr = (grant_idx == CH_W'(NUM_CH - 1)) ? '0 : grant_idx + 1'b1;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE, ST_RESP: state_next = accept ? ST_AFTER_ACCEPT : ST_IDLE;
            ST_WAIT:          if (cnt_reg == CNT_TERM) state_next = ST_RESP;
            default:          state_next = ST_IDLE;
        endcase
    end

    // Fault is evaluated one bit wider than the address so a+n never wraps.
    assign n_bytes  = 4'd1 << size_reg;
    assign end_addr = {1'b0, addr_reg} + {{(ADDR_W - 3){1'b0}}, n_bytes};
    assign fault    = (end_addr > MEM_LIMIT) || (size_reg > SIZE_MAX);

    generate
        for (genvar gi = 0; gi < MAX_BYTES; gi++) begin : g_lane
            assign lane_addr[gi] = MEM_AW'(addr_reg + ADDR_W'(gi));
        end
    endgenerate

    // Big-endian gather: mem[a] lands in the most significant accessed byte.
    always_comb begin
        rdata_next = '0;
        if (!fault && !we_reg) begin
            for (int i = 0; i < MAX_BYTES; i++) begin
                if (i < int'(n_bytes))
                    rdata_next[8*(int'(n_bytes) - 1 - i) +: 8] = mem[lane_addr[i]];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            cnt_reg        <= '0;
            rr_ptr_reg     <= '0;
            resp_valid_reg <= '0;
            resp_rdata_reg <= '0;
            resp_err_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= (state_reg == ST_WAIT) ? cnt_reg + 1'b1 : '0;
            resp_valid_reg <= '0;
            if (accept) rr_ptr_reg <= next_ptr;
            if (state_reg == ST_RESP) begin
                resp_valid_reg <= NUM_CH'(1) << ch_reg;
                resp_rdata_reg <= rdata_next;
                resp_err_reg   <= fault;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            ch_reg    <= grant_idx;
            we_reg    <= bus.req_we[grant_idx];
            size_reg  <= bus.req_size[grant_idx*2 +: 2];
            addr_reg  <= bus.req_addr[grant_idx*ADDR_W +: ADDR_W];
            wdata_reg <= bus.req_wdata[grant_idx*DATA_W +: DATA_W];
        end
    end

    // A reset during the transaction forces IDLE immediately, so no commit.
    always_ff @(posedge clk) begin
        if (state_reg == ST_RESP && we_reg && !fault) begin
            for (int i = 0; i < MAX_BYTES; i++) begin
                if (i < int'(n_bytes))
                    mem[lane_addr[i]] <= wdata_reg[8*(int'(n_bytes) - 1 - i) +: 8];
            end
        end
    end

    assign bus.req_ready  = req_ready_c;
    assign bus.resp_valid = resp_valid_reg;
    assign bus.resp_rdata = resp_rdata_reg;
    assign bus.resp_err   = resp_err_reg;
    assign bus.busy       = (state_reg != ST_IDLE);
endmodule

// File: tb/tb_tinker_mem_arb.sv
// Directed bench for tinker_mem_arb: a LATENCY=2 two-channel instance plus
// LATENCY=1 (32-bit) and LATENCY=5 (64-bit) instances for timing sweeps.
module tb_tinker_mem_arb;
    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    typedef struct { int cyc; int ch; } acc_t;
    typedef struct { int cyc; logic [1:0] vec; logic [63:0] data; logic err; } resp_t;
    acc_t  acc_q[$];
    resp_t resp_q[$];

    tinker_mem_arb_if #(.NUM_CH(2), .ADDR_W(32), .DATA_W(64)) m_if ();
    tinker_mem_arb_if #(.NUM_CH(2), .ADDR_W(32), .DATA_W(32)) a_if ();
    tinker_mem_arb_if #(.NUM_CH(2), .ADDR_W(32), .DATA_W(64)) b_if ();

    tinker_mem_arb #(.NUM_CH(2), .ADDR_W(32), .DATA_W(64), .MEM_BYTES(524288), .LATENCY(2))
        dut (.clk(clk), .reset(reset), .bus(m_if.slave));
    tinker_mem_arb #(.NUM_CH(2), .ADDR_W(32), .DATA_W(32), .MEM_BYTES(4096), .LATENCY(1))
        dut_l1 (.clk(clk), .reset(reset), .bus(a_if.slave));
    tinker_mem_arb #(.NUM_CH(2), .ADDR_W(32), .DATA_W(64), .MEM_BYTES(4096), .LATENCY(5))
        dut_l5 (.clk(clk), .reset(reset), .bus(b_if.slave));

    // Mid-cycle observation of the main instance: accepts and responses.
    always @(negedge clk) begin
        cyc++;
        if (|(m_if.req_valid & m_if.req_ready))
            acc_q.push_back('{cyc, (m_if.req_ready[1] ? 1 : 0)});
        if (|m_if.resp_valid)
            resp_q.push_back('{cyc, m_if.resp_valid, m_if.resp_rdata, m_if.resp_err});
    end

    task automatic drive(input int ch, input logic we, input logic [1:0] size,
                         input logic [31:0] addr, input logic [63:0] wdata);
        m_if.req_we[ch]             = we;
        m_if.req_size[ch*2 +: 2]    = size;
        m_if.req_addr[ch*32 +: 32]  = addr;
        m_if.req_wdata[ch*64 +: 64] = wdata;
        m_if.req_valid[ch]          = 1'b1;
    endtask

    task automatic single(input int ch, input logic we, input logic [1:0] size,
                          input logic [31:0] addr, input logic [63:0] wdata,
                          output resp_t r, output int lat, output bit ok);
        int na, nr;
        @(posedge clk); #1;
        na = acc_q.size(); nr = resp_q.size();
        ok = 1'b0; lat = -1; r = '{0, 2'b00, 64'd0, 1'b0};
        drive(ch, we, size, addr, wdata);
        for (int i = 0; i < 20 && acc_q.size() == na; i++) begin @(posedge clk); #1; end
        m_if.req_valid[ch] = 1'b0;
        for (int i = 0; i < 20 && resp_q.size() == nr; i++) begin @(posedge clk); #1; end
        if (acc_q.size() > na && resp_q.size() > nr) begin
            ok  = 1'b1;
            r   = resp_q[nr];
            lat = r.cyc - acc_q[na].cyc - 1;
        end
        $display("txn ch=%0d we=%0b size=%0d addr=%h wdata=%h -> resp=%b rdata=%h err=%b lat=%0d",
                 ch, we, size, addr, wdata, r.vec, r.data, r.err, lat);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (m_if.busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got=%b want=0", m_if.busy); end
        n_cmp++; if (m_if.resp_valid !== 2'b00) begin n_fail++; $display("FAIL rst_resp_valid got=%b want=00", m_if.resp_valid); end
        n_cmp++; if (m_if.resp_rdata !== 64'd0) begin n_fail++; $display("FAIL rst_rdata got=%h want=0", m_if.resp_rdata); end
        n_cmp++; if (m_if.resp_err !== 1'b0) begin n_fail++; $display("FAIL rst_err got=%b want=0", m_if.resp_err); end
        reset = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (m_if.req_ready !== 2'b00) begin n_fail++; $display("FAIL rst_ready_idle got=%b want=00", m_if.req_ready); end
        m_if.req_valid = 2'b11; #1;
        n_cmp++; if (m_if.req_ready !== 2'b01) begin n_fail++; $display("FAIL rst_ready_both got=%b want=01", m_if.req_ready); end
        m_if.req_valid = 2'b10; #1;
        n_cmp++; if (m_if.req_ready !== 2'b10) begin n_fail++; $display("FAIL rst_ready_ch1 got=%b want=10", m_if.req_ready); end
        m_if.req_valid = 2'b00;
    endtask

    task automatic test_store_load;
        resp_t r; int lat; bit ok;
        single(1, 1'b1, 2'd3, 32'h100, 64'h0102030405060708, r, lat, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL st8_timeout got=none want=response"); end
        n_cmp++; if (r.vec !== 2'b10) begin n_fail++; $display("FAIL st8_chan got=%b want=10", r.vec); end
        n_cmp++; if (lat !== 2) begin n_fail++; $display("FAIL st8_lat got=%0d want=2", lat); end
        n_cmp++; if (r.err !== 1'b0) begin n_fail++; $display("FAIL st8_err got=%b want=0", r.err); end
        single(0, 1'b0, 2'd2, 32'h100, 64'd0, r, lat, ok);
        n_cmp++; if (r.data !== 64'h01020304) begin n_fail++; $display("FAIL ld4_data got=%h want=01020304", r.data); end
        n_cmp++; if (r.vec !== 2'b01) begin n_fail++; $display("FAIL ld4_chan got=%b want=01", r.vec); end
        n_cmp++; if (lat !== 2) begin n_fail++; $display("FAIL ld4_lat got=%0d want=2", lat); end
        single(0, 1'b0, 2'd0, 32'h107, 64'd0, r, lat, ok);
        n_cmp++; if (r.data !== 64'h08) begin n_fail++; $display("FAIL ld1_data got=%h want=08", r.data); end
        single(0, 1'b0, 2'd1, 32'h103, 64'd0, r, lat, ok);
        n_cmp++; if (r.data !== 64'h0405) begin n_fail++; $display("FAIL ld2_misaligned got=%h want=0405", r.data); end
        single(0, 1'b0, 2'd3, 32'h100, 64'd0, r, lat, ok);
        n_cmp++; if (r.data !== 64'h0102030405060708) begin n_fail++; $display("FAIL ld8_data got=%h want=0102030405060708", r.data); end
    endtask

    // Last accept was channel 0, so the pointer sits at 1: grants go 1,0,1,0,...
    task automatic test_round_robin;
        int na, nr, c0, c1, k;
        logic [63:0] want;
        @(posedge clk); #1;
        na = acc_q.size(); nr = resp_q.size();
        drive(0, 1'b0, 2'd2, 32'h100, 64'd0);
        drive(1, 1'b0, 2'd2, 32'h104, 64'd0);
        for (int i = 0; i < 40 && m_if.req_valid != 2'b00; i++) begin
            @(posedge clk); #1;
            c0 = 0; c1 = 0;
            for (int j = na; j < acc_q.size(); j++) if (acc_q[j].ch == 0) c0++; else c1++;
            if (c0 >= 4) m_if.req_valid[0] = 1'b0;
            if (c1 >= 4) m_if.req_valid[1] = 1'b0;
        end
        m_if.req_valid = 2'b00;
        for (int i = 0; i < 10 && resp_q.size() < nr + 8; i++) begin @(posedge clk); #1; end
        n_cmp++; if (acc_q.size() - na !== 8) begin n_fail++; $display("FAIL rr_accepts got=%0d want=8", acc_q.size() - na); end
        n_cmp++; if (resp_q.size() - nr !== 8) begin n_fail++; $display("FAIL rr_resps got=%0d want=8", resp_q.size() - nr); end
        for (k = 0; k < 8 && na + k < acc_q.size() && nr + k < resp_q.size(); k++) begin
            n_cmp++; if (acc_q[na+k].ch !== ((k % 2 == 0) ? 1 : 0)) begin n_fail++; $display("FAIL rr_grant%0d got=%0d want=%0d", k, acc_q[na+k].ch, (k % 2 == 0) ? 1 : 0); end
            if (k > 0) begin
                n_cmp++; if (acc_q[na+k].cyc - acc_q[na+k-1].cyc !== 2) begin n_fail++; $display("FAIL rr_spacing%0d got=%0d want=2", k, acc_q[na+k].cyc - acc_q[na+k-1].cyc); end
            end
            want = (k % 2 == 0) ? 64'h05060708 : 64'h01020304;
            n_cmp++; if (resp_q[nr+k].data !== want) begin n_fail++; $display("FAIL rr_data%0d got=%h want=%h", k, resp_q[nr+k].data, want); end
            n_cmp++; if (resp_q[nr+k].vec !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin n_fail++; $display("FAIL rr_resp_chan%0d got=%b", k, resp_q[nr+k].vec); end
        end
    endtask

    task automatic test_fault;
        resp_t r; int lat; bit ok;
        single(0, 1'b1, 2'd1, 32'h7FFFE, 64'hBEEF, r, lat, ok);
        n_cmp++; if (r.err !== 1'b0) begin n_fail++; $display("FAIL flt_edge_store err got=%b want=0", r.err); end
        single(0, 1'b1, 2'd2, 32'h7FFFE, 64'h11223344, r, lat, ok);
        n_cmp++; if (r.err !== 1'b1) begin n_fail++; $display("FAIL flt_over_store err got=%b want=1", r.err); end
        n_cmp++; if (r.data !== 64'd0) begin n_fail++; $display("FAIL flt_over_store rdata got=%h want=0", r.data); end
        n_cmp++; if (lat !== 2) begin n_fail++; $display("FAIL flt_over_store lat got=%0d want=2", lat); end
        single(0, 1'b0, 2'd1, 32'h7FFFE, 64'd0, r, lat, ok);
        n_cmp++; if (r.data !== 64'hBEEF) begin n_fail++; $display("FAIL flt_readback got=%h want=beef", r.data); end
        n_cmp++; if (r.err !== 1'b0) begin n_fail++; $display("FAIL flt_readback err got=%b want=0", r.err); end
        single(0, 1'b0, 2'd3, 32'hFFFFFFFC, 64'd0, r, lat, ok);
        n_cmp++; if (r.err !== 1'b1) begin n_fail++; $display("FAIL flt_nowrap err got=%b want=1", r.err); end
        n_cmp++; if (r.data !== 64'd0) begin n_fail++; $display("FAIL flt_nowrap rdata got=%h want=0", r.data); end
        single(1, 1'b0, 2'd0, 32'h80000, 64'd0, r, lat, ok);
        n_cmp++; if (r.err !== 1'b1) begin n_fail++; $display("FAIL flt_past_end err got=%b want=1", r.err); end
    endtask

    task automatic test_back_to_back;
        resp_t r; int lat; bit ok; int na, nr;
        single(0, 1'b1, 2'd2, 32'h200, 64'd0, r, lat, ok);
        @(posedge clk); #1;
        na = acc_q.size(); nr = resp_q.size();
        drive(1, 1'b1, 2'd2, 32'h200, 64'hCAFEF00D);
        for (int i = 0; i < 10 && acc_q.size() == na; i++) begin @(posedge clk); #1; end
        m_if.req_valid[1] = 1'b0;
        drive(0, 1'b0, 2'd2, 32'h200, 64'd0);
        for (int i = 0; i < 10 && acc_q.size() == na + 1; i++) begin @(posedge clk); #1; end
        m_if.req_valid[0] = 1'b0;
        for (int i = 0; i < 10 && resp_q.size() < nr + 2; i++) begin @(posedge clk); #1; end
        n_cmp++; if (acc_q.size() - na !== 2 || resp_q.size() - nr !== 2) begin n_fail++; $display("FAIL b2b_count got=%0d/%0d want=2/2", acc_q.size() - na, resp_q.size() - nr); end
        if (acc_q.size() >= na + 2 && resp_q.size() >= nr + 2) begin
            n_cmp++; if (acc_q[na+1].cyc - acc_q[na].cyc !== 2) begin n_fail++; $display("FAIL b2b_spacing got=%0d want=2", acc_q[na+1].cyc - acc_q[na].cyc); end
            n_cmp++; if (acc_q[na].ch !== 1 || acc_q[na+1].ch !== 0) begin n_fail++; $display("FAIL b2b_order got=%0d,%0d want=1,0", acc_q[na].ch, acc_q[na+1].ch); end
            n_cmp++; if (resp_q[nr+1].data !== 64'hCAFEF00D) begin n_fail++; $display("FAIL b2b_raw got=%h want=cafef00d", resp_q[nr+1].data); end
            n_cmp++; if (resp_q[nr+1].cyc - resp_q[nr].cyc !== 2) begin n_fail++; $display("FAIL b2b_resp_gap got=%0d want=2", resp_q[nr+1].cyc - resp_q[nr].cyc); end
            n_cmp++; if (resp_q[nr].vec !== 2'b10 || resp_q[nr+1].vec !== 2'b01) begin n_fail++; $display("FAIL b2b_chan got=%b,%b want=10,01", resp_q[nr].vec, resp_q[nr+1].vec); end
        end
        $display("txn b2b store ch1 @200 then load ch0 @200");
    endtask

    task automatic test_reset_mid;
        resp_t r; int lat; bit ok; int na, nr;
        single(0, 1'b1, 2'd0, 32'h300, 64'h55, r, lat, ok);
        @(posedge clk); #1;
        na = acc_q.size(); nr = resp_q.size();
        drive(0, 1'b1, 2'd0, 32'h300, 64'hAA);
        for (int i = 0; i < 10 && acc_q.size() == na; i++) begin @(posedge clk); #1; end
        m_if.req_valid[0] = 1'b0;
        n_cmp++; if (m_if.busy !== 1'b1) begin n_fail++; $display("FAIL rstmid_busy_before got=%b want=1", m_if.busy); end
        @(posedge clk); #1;
        reset = 1'b1; #1;
        n_cmp++; if (m_if.busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy_async got=%b want=0", m_if.busy); end
        repeat (2) @(posedge clk);
        #1; reset = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        n_cmp++; if (resp_q.size() !== nr) begin n_fail++; $display("FAIL rstmid_no_resp got=%0d want=%0d", resp_q.size(), nr); end
        m_if.req_valid = 2'b11; #1;
        n_cmp++; if (m_if.req_ready !== 2'b01) begin n_fail++; $display("FAIL rstmid_first_grant got=%b want=01", m_if.req_ready); end
        m_if.req_valid = 2'b00;
        single(0, 1'b0, 2'd0, 32'h300, 64'd0, r, lat, ok);
        n_cmp++; if (r.data !== 64'h55) begin n_fail++; $display("FAIL rstmid_mem_kept got=%h want=55", r.data); end
        $display("txn reset mid-store ch0 @300");
    endtask

    // sel=0 drives the LATENCY=1 32-bit instance, sel=1 the LATENCY=5 one.
    task automatic sweep(input bit sel, input int lat, input logic we, input logic [1:0] size,
                         input logic [31:0] addr, input logic [63:0] wdata,
                         input logic [63:0] exp_rdata, input logic exp_err);
        logic bz, rv, er, rdy;
        logic [63:0] rd;
        @(posedge clk); #1;
        if (!sel) begin
            a_if.req_we[0] = we; a_if.req_size[1:0] = size; a_if.req_addr[31:0] = addr;
            a_if.req_wdata[31:0] = wdata[31:0]; a_if.req_valid[0] = 1'b1;
        end else begin
            b_if.req_we[0] = we; b_if.req_size[1:0] = size; b_if.req_addr[31:0] = addr;
            b_if.req_wdata[63:0] = wdata; b_if.req_valid[0] = 1'b1;
        end
        #1;
        rdy = sel ? b_if.req_ready[0] : a_if.req_ready[0];
        n_cmp++; if (rdy !== 1'b1) begin n_fail++; $display("FAIL sweep_L%0d_ready got=%b want=1", lat, rdy); end
        @(posedge clk); #1;
        a_if.req_valid = 2'b00; b_if.req_valid = 2'b00;
        rd = 64'd0; er = 1'b0;
        for (int k = 0; k <= lat + 1; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            bz = sel ? b_if.busy : a_if.busy;
            rv = sel ? b_if.resp_valid[0] : a_if.resp_valid[0];
            n_cmp++; if (bz !== (k < lat)) begin n_fail++; $display("FAIL sweep_L%0d_busy k=%0d got=%b want=%b", lat, k, bz, k < lat); end
            n_cmp++; if (rv !== (k == lat)) begin n_fail++; $display("FAIL sweep_L%0d_resp k=%0d got=%b want=%b", lat, k, rv, k == lat); end
            if (k == lat) begin
                rd = sel ? b_if.resp_rdata : {32'd0, a_if.resp_rdata};
                er = sel ? b_if.resp_err : a_if.resp_err;
                n_cmp++; if (er !== exp_err) begin n_fail++; $display("FAIL sweep_L%0d_err got=%b want=%b", lat, er, exp_err); end
                if (!we || exp_err) begin
                    n_cmp++; if (rd !== exp_rdata) begin n_fail++; $display("FAIL sweep_L%0d_rdata got=%h want=%h", lat, rd, exp_rdata); end
                end
            end
        end
        $display("txn L=%0d we=%0b size=%0d addr=%h wdata=%h -> rdata=%h err=%b", lat, we, size, addr, wdata, rd, er);
    endtask

    task automatic test_latency_sweep;
        sweep(1'b0, 1, 1'b1, 2'd2, 32'h10,  64'h89ABCDEF, 64'd0,         1'b0);
        sweep(1'b0, 1, 1'b0, 2'd2, 32'h10,  64'd0,        64'h89ABCDEF,  1'b0);
        sweep(1'b0, 1, 1'b0, 2'd1, 32'h11,  64'd0,        64'hABCD,      1'b0);
        sweep(1'b0, 1, 1'b0, 2'd3, 32'h10,  64'd0,        64'd0,         1'b1);
        sweep(1'b0, 1, 1'b1, 2'd2, 32'hFFE, 64'h12345678, 64'd0,         1'b1);
        sweep(1'b1, 5, 1'b1, 2'd3, 32'h20,  64'h1122334455667788, 64'd0, 1'b0);
        sweep(1'b1, 5, 1'b0, 2'd3, 32'h20,  64'd0, 64'h1122334455667788, 1'b0);
        sweep(1'b1, 5, 1'b0, 2'd2, 32'h22,  64'd0, 64'h33445566,         1'b0);
    endtask

    initial begin
        m_if.req_valid = '0; m_if.req_we = '0; m_if.req_size = '0; m_if.req_addr = '0; m_if.req_wdata = '0;
        a_if.req_valid = '0; a_if.req_we = '0; a_if.req_size = '0; a_if.req_addr = '0; a_if.req_wdata = '0;
        b_if.req_valid = '0; b_if.req_we = '0; b_if.req_size = '0; b_if.req_addr = '0; b_if.req_wdata = '0;
        test_reset;
        test_store_load;
        test_round_robin;
        test_fault;
        test_back_to_back;
        test_reset_mid;
        test_latency_sweep;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
